instruction_queue: RTL and testbench
====================================

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 The module SHALL have parameter DEPTH, default 8, setting the number of entries (power of two, >= 2).
REQ-003 iq_valid  input  1  fetch offers an entry this cycle.
REQ-004 pc  input  32  fetch address of the offered instruction.
REQ-005 inst  input  32  offered instruction word.
REQ-006 pc_next  input  32  predicted next PC for the offered instruction.
REQ-007 br_pred  input  1  predicted-taken flag for the offered instruction.
REQ-008 iq_ready  output  1  queue can accept an entry this cycle.
REQ-009 flush  input  1  discard all entries.
REQ-010 deq  input  1  downstream consumes the head entry this cycle.
REQ-011 out_valid  output  1  head entry is valid.
REQ-012 out_pc, out_inst, out_pc_next  output  32 each  head entry fields.
REQ-013 out_br_pred  output  1  head entry prediction flag.
REQ-014 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 iq_ready SHALL equal !full, where full is (count == DEPTH), with no combinational dependence on deq.
REQ-016 Enqueue SHALL occur at a rising edge when iq_valid && iq_ready && !flush; {pc, inst, pc_next, br_pred} are written at the tail, and the tail pointer advances by 1 modulo DEPTH.
REQ-017 Dequeue SHALL occur at a rising edge when deq && out_valid && !flush; the head pointer advances by 1 modulo DEPTH.
REQ-018 deq while out_valid is low SHALL be ignored.
REQ-019 iq_valid while full SHALL be ignored: the entry is dropped and no state changes.
REQ-020 Fetch holds only one outstanding request. Because iq_ready is sampled before that request is issued, a full queue at delivery time cannot occur in legal operation.
REQ-021 Head outputs SHALL be a combinational read of the head entry. out_valid = (count != 0).
REQ-022 Head outputs SHALL hold their values while out_valid is high and deq is low.
REQ-023 Latency: an entry enqueued at edge N SHALL appear on the outputs after edge N when the queue was empty. There is no same-cycle input-to-output bypass.
REQ-024 A simultaneous enqueue and dequeue SHALL leave count unchanged, with both pointers advancing.
REQ-025 When full, a dequeue in the same cycle SHALL NOT allow an enqueue, because iq_ready is already low.
REQ-026 Flush SHALL take priority over enqueue and dequeue: at the edge, head = tail = 0 and count = 0; out_valid and iq_ready reflect this in the next cycle.
REQ-027 Entries SHALL leave in exactly the order they entered, including across pointer wrap-around.
REQ-028 Storage contents SHALL NOT be cleared on flush or reset; only pointers and count are cleared.

Reset
REQ-029 At a rising edge with rst high: head = 0, tail = 0, count = 0.
REQ-030 After that reset edge, out_valid = 0 and iq_ready = 1, and rst SHALL take priority over flush, enqueue and dequeue.
REQ-031 Reset asserted mid-operation SHALL discard all entries exactly as flush does.
REQ-032 Head data outputs are don't-care while out_valid = 0.

Structure
REQ-033 An iq_entry_t struct {rv32i_word pc, inst, pc_next; logic br_pred} SHALL be added to package rv32i_types and used for the storage array.
REQ-034 The design SHALL be a single module with no sub-module: a DEPTH-entry iq_entry_t array, head and tail pointers of $clog2(DEPTH) bits, and a count register.

Verification
REQ-035 Empty, then enqueue pc=0x60 inst=0x00000013 pc_next=0x64 br_pred=0 -> next cycle out_valid=1, out_pc=0x60, count=1; deq -> out_valid=0.
REQ-036 Enqueue 8 entries (pc 0x60..0x7C) with no deq -> iq_ready=0 and count=8; iq_valid with pc=0x80 -> dropped; 8 deqs return 0x60..0x7C in order.
REQ-037 Hold count=3 with simultaneous enqueue and deq for 20 cycles -> count stays 3, order preserved across pointer wrap.
REQ-038 count=5, flush together with iq_valid and deq -> next cycle count=0, out_valid=0, iq_ready=1, and the offered entry is absent.
REQ-039 count=4, rst pulse -> count=0, out_valid=0; then enqueue pc=0x60 -> visible at head after one edge.
REQ-040 Full queue with deq and iq_valid in the same cycle -> count=7 and the input is not enqueued.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types: the machine word and the instruction-queue entry layout.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  // One fetched instruction together with its branch-prediction metadata.
  typedef struct packed {
    rv32i_word pc;
    rv32i_word inst;
    rv32i_word pc_next;
    logic      br_pred;
  } iq_entry_t;

endpackage : rv32i_types

// File: rtl/instruction_queue.sv
// Circular instruction queue between fetch and decode. The head entry is
// presented combinationally; pointers and occupancy are the only reset state,
// so the payload array needs no reset and maps cleanly onto RAM.
module instruction_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iq_valid,
  input  logic [31:0]                pc,
  input  logic [31:0]                inst,
  input  logic [31:0]                pc_next,
  input  logic                       br_pred,
  output logic                       iq_ready,
  input  logic                       flush,
  input  logic                       deq,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc_next,
  output logic                       out_br_pred,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_enq;
  logic               w_deq;
  iq_entry_t          w_wr_entry;
  iq_entry_t          w_head_entry;

  // Ready depends only on occupancy, never on deq, so fetch sees a stable
  // handshake; reset and flush suppress any state-changing transfer.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == {CNT_W{1'b0}});
  assign w_enq    = iq_valid && !w_full && !flush && !rst;
  assign w_deq    = deq && !w_empty && !flush && !rst;

  assign w_wr_entry = '{pc: pc, inst: inst, pc_next: pc_next, br_pred: br_pred};
  assign w_head_entry = r_mem[r_head];

  assign iq_ready    = !w_full;
  assign out_valid   = !w_empty;
  assign out_pc      = w_head_entry.pc;
  assign out_inst    = w_head_entry.inst;
  assign out_pc_next = w_head_entry.pc_next;
  assign out_br_pred = w_head_entry.br_pred;
  assign count       = r_count;

  // Payload write at the tail; intentionally not reset or cleared on flush.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail] <= w_wr_entry;
    end
  end

  // Pointer and occupancy update: reset, then flush, then normal traffic.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (flush) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : instruction_queue

// File: tb/tb_instruction_queue.sv
// Randomized and directed bench for instruction_queue, scored against a
// queue-based FIFO model that follows the behavioural rules directly.
module tb_instruction_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        iq_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] pc_next;
  logic        br_pred;
  logic        iq_ready;
  logic        flush;
  logic        deq;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_pc_next;
  logic        out_br_pred;
  logic [3:0]  count;

  int n_vec;
  int n_err;

  iq_entry_t model_q[$];

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .iq_valid    (iq_valid),
    .pc          (pc),
    .inst        (inst),
    .pc_next     (pc_next),
    .br_pred     (br_pred),
    .iq_ready    (iq_ready),
    .flush       (flush),
    .deq         (deq),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_pc_next (out_pc_next),
    .out_br_pred (out_br_pred),
    .count       (count)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all visible outputs against the model state for this cycle.
  task automatic check_outputs();
    int sz;
    sz = model_q.size();
    check_eq("count", 32'(count), 32'(sz));
    check_eq("out_valid", 32'(out_valid), 32'(sz != 0));
    check_eq("iq_ready", 32'(iq_ready), 32'(sz != DEPTH));
    if (sz != 0) begin
      check_eq("out_pc", out_pc, model_q[0].pc);
      check_eq("out_inst", out_inst, model_q[0].inst);
      check_eq("out_pc_next", out_pc_next, model_q[0].pc_next);
      check_eq("out_br_pred", 32'(out_br_pred), 32'(model_q[0].br_pred));
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then apply the FIFO
  // rules to the model at the rising edge.
  task automatic cycle(input logic v, input logic [31:0] a_pc, input logic [31:0] a_inst,
                       input logic [31:0] a_pcn, input logic a_bp, input logic a_deq,
                       input logic a_flush, input logic a_rst);
    iq_entry_t e;
    bit do_enq;
    bit do_deq;
    iq_valid = v;
    pc       = a_pc;
    inst     = a_inst;
    pc_next  = a_pcn;
    br_pred  = a_bp;
    deq      = a_deq;
    flush    = a_flush;
    rst      = a_rst;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (a_rst || a_flush) begin
      model_q.delete();
    end else begin
      do_enq = v && (model_q.size() < DEPTH);
      do_deq = a_deq && (model_q.size() > 0);
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) begin
        e.pc = a_pc; e.inst = a_inst; e.pc_next = a_pcn; e.br_pred = a_bp;
        model_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enq(input logic [31:0] a_pc, input logic a_deq);
    cycle(1'b1, a_pc, $urandom, a_pc + 32'd4, 1'($urandom), a_deq, 1'b0, 1'b0);
  endtask

  // Empty the queue and enqueue n sequential entries starting at pc 0x60.
  task automatic fill_to(input int n);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) enq(32'h60 + 32'(4 * i), 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    iq_valid = 1'b0; pc = 32'h0; inst = 32'h0; pc_next = 32'h0;
    br_pred = 1'b0; deq = 1'b0; flush = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_count", 32'(count), 32'd0);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_iq_ready", 32'(iq_ready), 32'd1);

    // Single entry round trip with one-edge latency.
    cycle(1'b1, 32'h60, 32'h00000013, 32'h64, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("single_pc", out_pc, 32'h60);
    check_eq("single_count", 32'(count), 32'd1);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("single_deq_valid", 32'(out_valid), 32'd0);

    // Fill to capacity, drop an extra offer, drain in order.
    fill_to(DEPTH);
    check_eq("full_ready", 32'(iq_ready), 32'd0);
    check_eq("full_count", 32'(count), 32'd8);
    cycle(1'b1, 32'h80, 32'h0, 32'h84, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("full_drop_count", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("drain_pc", out_pc, 32'h60 + 32'(4 * i));
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_eq("drained_valid", 32'(out_valid), 32'd0);

    // Steady occupancy of 3 with simultaneous enqueue and dequeue across wrap.
    fill_to(3);
    for (int i = 0; i < 20; i++) enq(32'h100 + 32'(4 * i), 1'b1);
    check_eq("steady_count", 32'(count), 32'd3);
    check_eq("steady_head", out_pc, 32'h100 + 32'(4 * 17));

    // Flush beats a concurrent enqueue and dequeue.
    fill_to(5);
    cycle(1'b1, 32'hABC0, 32'h1, 32'hABC4, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_ready", 32'(iq_ready), 32'd1);
    idle();

    // Full queue: dequeue happens, the concurrent offer does not.
    fill_to(DEPTH);
    cycle(1'b1, 32'h200, 32'h0, 32'h204, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("full_deq_count", 32'(count), 32'd7);
    check_eq("full_deq_head", out_pc, 32'h64);

    // Reset mid-operation, then one entry shows up after one edge.
    fill_to(4);
    cycle(1'b1, 32'h300, 32'h0, 32'h304, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    cycle(1'b1, 32'h60, 32'h00000013, 32'h64, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_then_enq_pc", out_pc, 32'h60);
    check_eq("rst_then_enq_count", 32'(count), 32'd1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 9) < 6), $urandom, $urandom, $urandom, 1'($urandom),
            1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 63) == 0));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instruction_queue
